// File: rtl/rom_pkg.sv
// Shared definitions for the 16x4 ROM read path: default widths and the
// burst sequencer state encoding.
package rom_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer names the winner on contention
// and moves to the other requester whenever a pick is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] pick
);

    logic rr;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = rr ? 2'b10 : 2'b01;
        end
    end

    // After granting 0 the pointer favours 1, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (accept && (pick != 2'b00)) begin
            rr <= pick[0];
        end
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Two-port burst read arbiter and sequencer for the 16x4 synchronous ROM.
// Optional burst XOR checksum on rd_csum is built when ROM_RD_ARB_CSUM_EN is defined.
module rom_rd_arbiter
    import rom_pkg::*;
#(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_id,
    output logic              rd_last,
    output logic [DATA_W-1:0] rd_csum
);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] cnt;
    logic              id;
    logic [1:0]        pick;
    logic              accept;
    logic              issue_last;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .pick   (pick)
    );

    always_comb begin
        nxt        = state;
        accept     = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    accept = 1'b1;
                    nxt    = ISSUE;
                end
            end
            ISSUE: begin
                issue_last = (cnt == '0);
                if (issue_last) begin
                    nxt = DRAIN;
                end
            end
            DRAIN:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign rom_en   = (state == ISSUE);
    assign rom_addr = rom_en ? cur_addr : '0;
    assign busy     = (state != IDLE);
    assign rd_data  = rom_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            cur_addr <= '0;
            cnt      <= '0;
            id       <= 1'b0;
        end else begin
            state <= nxt;
            gnt   <= accept ? pick : 2'b00;
            if (accept) begin
                cur_addr <= pick[1] ? addr1 : addr0;
                cnt      <= pick[1] ? len1 : len0;
                id       <= pick[1];
            end else if (rom_en) begin
                // Address wraps naturally at the ADDR_W boundary.
                cur_addr <= cur_addr + ADDR_W'(1);
                cnt      <= cnt - ADDR_W'(1);
            end
        end
    end

    // Return strobes trail the ROM request by its one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            rd_valid <= rom_en;
            rd_last  <= issue_last;
            rd_id    <= id;
        end
    end

`ifdef ROM_RD_ARB_CSUM_EN
    logic [DATA_W-1:0] acc;

    // acc holds the XOR of every beat before the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (rd_valid) begin
            acc <= acc ^ rom_dout;
        end
    end

    assign rd_csum = rd_last ? (acc ^ rom_dout) : '0;
`else
    assign rd_csum = '0;
`endif

endmodule

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Two-port read arbiter and burst sequencer for the 16x4 synchronous ROM.
- Accepts burst read requests from two requesters and grants them round-robin.
- Drives the ROM's `en`/`addr` one beat per cycle with address wrap-around.
- Returns tagged read data with valid/last strobes.
- Sits between the ROM instance and its clients, so the ROM has exactly one driver.

## Interface
- `ADDR_W`, 4, ROM address width (16 locations)
- `DATA_W`, 4, ROM data width
- `clk`  in  1  rising-edge clock, shared with the ROM
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  2  per-requester request level; bit i = requester i
- `addr0`, `addr1`  in  ADDR_W  burst start address of requester 0 / 1
- `len0`, `len1`  in  ADDR_W  burst length minus one (0 → 1 beat, 15 → 16 beats)
- `gnt`  out  2  one-hot, single-cycle grant pulse
- `busy`  out  1  high while a burst is in ISSUE or DRAIN
- `rom_en`  out  1  ROM enable
- `rom_addr`  out  ADDR_W  ROM address
- `rom_dout`  in  DATA_W  ROM registered read data
- `rd_data`  out  DATA_W  returned beat
- `rd_valid`  out  1  `rd_data` valid this cycle
- `rd_id`  out  1  requester index owning the current beat
- `rd_last`  out  1  final beat of the burst
- `rd_csum`  out  DATA_W  burst checksum, valid with `rd_last`

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: if any `req` bit is high, pick a winner.
  - Only one requesting → it wins.
  - Both requesting → the one indicated by round-robin pointer `rr` wins.
  - On selection: latch winner's addr/len into `cur_addr` and `cnt`, latch id, pulse `gnt[id]`, go to ISSUE.
  - After a grant to i, `rr` points to the other requester (1−i).
- ISSUE: `rom_en`=1, `rom_addr`=`cur_addr`.
  - Each cycle: `cur_addr` += 1, modulo 2^ADDR_W (15 wraps to 0); `cnt` −= 1.
  - When ISSUE is entered or stays with `cnt`==0, that beat is the last; next state is DRAIN.
- DRAIN: `rom_en`=0; one cycle to collect the last beat; then IDLE.
- Requester contract:
  - Hold `req`, address and length stable until `gnt` is seen.
  - Drop `req` in the cycle after `gnt` unless it wants another burst.
  - Deasserting `req` before grant withdraws the request.
- `rd_valid`, `rd_last`, `rd_id`: registered one-cycle delayed copies of `rom_en`, the issue-last flag, and the latched id.
- `rd_data` = `rom_dout` passthrough; meaningful only when `rd_valid`=1.
- No back-pressure: clients must accept every valid beat.
- `rom_en`=0 outside ISSUE. The ROM's output in that case is don't-care and never reaches a valid beat.
- Reset, including mid-burst:
  - State → IDLE, `rr`=0, `cnt`/`cur_addr`/checksum cleared.
  - All outputs 0: `gnt`, `busy`, `rom_en`, `rom_addr`, `rd_valid`, `rd_id`, `rd_last`, `rd_csum`.
  - An interrupted burst is abandoned; no partial `rd_last` is produced.

## Timing
- `req` sampled in IDLE at edge T → `gnt` and `busy` high in cycle T+1, with the first `rom_en` in the same cycle.
- A burst of N beats drives `rom_en` for cycles T+1..T+N.
- `rd_valid` is high for cycles T+2..T+N+1; `rd_last` is high at T+N+1.
- DRAIN occupies T+N+1, IDLE T+N+2. The earliest next grant is visible at T+N+3.
- Burst occupancy is N+2 cycles, so back-to-back requests achieve N/(N+2) throughput.
- Read latency is 1 cycle from `rom_en` to `rd_valid`.

## Configuration
- `ROM_RD_ARB_CSUM_EN` defined:
  - `rd_csum` accumulates the XOR of all beats of the current burst.
  - It is cleared at grant and presents the full-burst XOR in the `rd_last` cycle.
  - It is 0 in all other cycles.
- Not defined: `rd_csum` is tied to 0 and no accumulator is built.

## Structure
- Shared package `rom_pkg`: `ADDR_W`/`DATA_W` defaults and the state enum (IDLE, ISSUE, DRAIN).
- One sub-module, `rr_arb2`: 2-way round-robin picker (req in, one-hot pick out, pointer update on accept).
- The FSM, address/count registers and return pipeline live in the top.

## Test plan
ROM contents are the codebase's fixed 16-entry table (e.g. 10→A, 12→A, 13→F, 14→2, 15→0).
- Reset mid-burst:
  - Stimulus: assert `rst` during ISSUE.
  - Required: all outputs 0 immediately (async); no `rd_last`; after release the next `req[1]` is granted.
- Single burst:
  - Stimulus: `req[0]`, addr0=12, len0=3.
  - Required: `gnt`=01 one cycle; `rd_data` A,F,2,0 on 4 consecutive valid cycles, `rd_id`=0, `rd_last` on beat 4; `rd_csum`=7 (with CSUM_EN).
- Wrap:
  - Stimulus: `req[1]`, addr1=14, len1=2.
  - Required: `rom_addr` 14,15,0; `rd_data` 2,0,2; `rd_id`=1; `rd_csum`=0.
- Contention after reset:
  - Stimulus: both `req` high, addr0=10/len0=0, addr1=13/len1=0.
  - Required: port 0 granted first (data A); port 1 granted 3 cycles after `gnt`[0] (data F).
- Fairness:
  - Stimulus: both requests held continuously for 4 grants.
  - Required: grant order 0,1,0,1, with `gnt` pulses spaced N+2 cycles apart.
- Withdrawn request:
  - Stimulus: `req[1]` pulses only during an active port-0 burst.
  - Required: `gnt[1]` is never asserted.
